// File: rtl/alu_op_sequencer.sv
// Issue sequencer in front of the ALU opcode decoder: 2-entry opcode queue, EXEC timing per op
// latency, and a completion handshake. All outputs come straight from registers.
module alu_op_sequencer #(
    parameter int unsigned OP_WIDTH  = 5,
    parameter int unsigned MULTI_LAT = 4
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_req_valid,
    input  logic [OP_WIDTH-1:0] i_req_op,
    output logic                o_req_ready,
    output logic [OP_WIDTH-1:0] o_op_sel,
    output logic                o_op_en,
    output logic                o_done_valid,
    output logic [OP_WIDTH-1:0] o_done_op,
    input  logic                i_done_ready
);
    localparam int unsigned CNT_W = $clog2(MULTI_LAT + 1);

    typedef enum logic [1:0] {StIdle, StExec, StResp} state_t;

    state_t              r_state;
    logic [OP_WIDTH-1:0] r_cur_op;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_op_en;
    logic [OP_WIDTH-1:0] r_op_sel;
    logic                r_done_valid;
    logic [OP_WIDTH-1:0] r_done_op;

    logic [OP_WIDTH-1:0] r_mem [2];
    logic                r_wptr;
    logic                r_rptr;
    logic [1:0]          r_count;

    logic                w_push;
    logic                w_pop;
    logic [OP_WIDTH-1:0] w_head;
    logic [CNT_W-1:0]    w_head_cnt;

    // Ready comes from the registered count only, so a same-cycle pop never frees a slot early.
    assign o_req_ready = (r_count != 2'd2);
    assign w_push      = i_req_valid && o_req_ready;
    assign w_pop       = (r_count != 2'd0) &&
                         ((r_state == StIdle) || ((r_state == StResp) && i_done_ready));
    assign w_head      = r_mem[r_rptr];
    assign w_head_cnt  = w_head[OP_WIDTH-1] ? CNT_W'(MULTI_LAT - 1) : '0;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wptr   <= 1'b0;
            r_rptr   <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= i_req_op;
                r_wptr        <= ~r_wptr;
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= StIdle;
            r_cur_op     <= '0;
            r_cnt        <= '0;
            r_op_en      <= 1'b0;
            r_op_sel     <= '0;
            r_done_valid <= 1'b0;
            r_done_op    <= '0;
        end else begin
            unique case (r_state)
                StIdle: ;
                StExec: begin
                    if (r_cnt == '0) begin
                        r_state      <= StResp;
                        r_op_en      <= 1'b0;
                        r_op_sel     <= '0;
                        r_done_valid <= 1'b1;
                        r_done_op    <= r_cur_op;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                StResp: begin
                    if (i_done_ready) begin
                        r_state      <= StIdle;
                        r_done_valid <= 1'b0;
                        r_done_op    <= '0;
                    end
                end
                default: r_state <= StIdle;
            endcase
            // A pop always starts the head op; overrides the Idle fall-back after a handshake.
            if (w_pop) begin
                r_state  <= StExec;
                r_cur_op <= w_head;
                r_cnt    <= w_head_cnt;
                r_op_en  <= 1'b1;
                r_op_sel <= w_head;
            end
        end
    end

    assign o_op_en      = r_op_en;
    assign o_op_sel     = r_op_sel;
    assign o_done_valid = r_done_valid;
    assign o_done_op    = r_done_op;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: directed scenarios then random traffic, checked each cycle against
// a timestamp model (accept edge, start edge, handshake edge) of the queue and issue rules.
module tb_alu_op_sequencer;
    localparam int OPW = 5;
    localparam int ML  = 4;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           req_valid = 1'b0;
    logic [OPW-1:0] req_op = '0;
    logic           done_ready = 1'b0;
    logic           req_ready;
    logic [OPW-1:0] op_sel;
    logic           op_en;
    logic           done_valid;
    logic [OPW-1:0] done_op;

    alu_op_sequencer #(.OP_WIDTH(OPW), .MULTI_LAT(ML)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_req_valid  (req_valid),
        .i_req_op     (req_op),
        .o_req_ready  (req_ready),
        .o_op_sel     (op_sel),
        .o_op_en      (op_en),
        .o_done_valid (done_valid),
        .o_done_op    (done_op),
        .i_done_ready (done_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [OPW-1:0] op;
        int             acc;
    } ent_t;

    ent_t           pend[$];
    bit             act;
    logic [OPW-1:0] act_op;
    int             act_s;
    int             act_l;
    int             edge_n;
    int             n_vec;
    int             n_err;

    task automatic chk(input string tag, input logic [OPW-1:0] got, input logic [OPW-1:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Op i starts at edge max(accept+1, previous handshake), runs L edges, then waits for ready.
    task automatic model_edge();
        bit             rdy_pre;
        logic [OPW-1:0] hop;
        edge_n++;
        if (!rst_n) return;
        rdy_pre = pend.size() < 2;
        if (act && edge_n >= act_s + act_l + 1 && done_ready) act = 1'b0;
        if (req_valid && rdy_pre) pend.push_back('{req_op, edge_n});
        if (!act && pend.size() > 0 && pend[0].acc < edge_n) begin
            hop    = pend[0].op;
            act    = 1'b1;
            act_op = hop;
            act_s  = edge_n;
            act_l  = hop[OPW-1] ? ML : 1;
            void'(pend.pop_front());
        end
    endtask

    task automatic check_outputs(input string tag);
        logic en;
        logic dv;
        en = act && (edge_n < act_s + act_l);
        dv = act && (edge_n >= act_s + act_l);
        chk({tag, ".req_ready"}, req_ready, pend.size() < 2);
        chk({tag, ".op_en"}, op_en, en);
        chk({tag, ".op_sel"}, op_sel, en ? act_op : '0);
        chk({tag, ".done_valid"}, done_valid, dv);
        chk({tag, ".done_op"}, done_op, dv ? act_op : '0);
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_outputs(tag);
    endtask

    task automatic steps(input string tag, input int n);
        for (int i = 0; i < n; i++) step(tag);
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear without waiting for a clock edge.
    task automatic mid_reset(input string tag);
        #2;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        #1;
        chk({tag, ".rst_op_en"}, op_en, 1'b0);
        chk({tag, ".rst_op_sel"}, op_sel, '0);
        chk({tag, ".rst_done_valid"}, done_valid, 1'b0);
        chk({tag, ".rst_done_op"}, done_op, '0);
        chk({tag, ".rst_req_ready"}, req_ready, 1'b1);
        pend.delete();
        act = 1'b0;
        step(tag);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic push(input string tag, input logic [OPW-1:0] op);
        req_valid = 1'b1;
        req_op    = op;
        step(tag);
        req_valid = 1'b0;
    endtask

    initial begin
        n_vec  = 0;
        n_err  = 0;
        edge_n = 0;
        act    = 1'b0;

        steps("por", 2);
        @(negedge clk);
        rst_n = 1'b1;
        step("post_por");

        done_ready = 1'b1;
        push("single", 5'h03);
        steps("single", 4);

        push("multi", 5'h12);
        steps("multi", 7);

        done_ready = 1'b0;
        push("bp", 5'h01);
        push("bp", 5'h02);
        push("bp", 5'h03);
        chk("bp_full_ready", req_ready, 1'b0);
        req_valid = 1'b1;
        req_op    = 5'h04;
        steps("bp_stall", 4);
        req_valid = 1'b0;
        steps("bp_hold", 3);
        done_ready = 1'b1;
        steps("bp_drain", 10);

        done_ready = 1'b0;
        push("pp", 5'h12);
        push("pp", 5'h01);
        steps("pp", 4);
        done_ready = 1'b1;
        req_valid  = 1'b1;
        req_op     = 5'h07;
        step("pp_pushpop");
        req_valid = 1'b0;
        chk("pp_count1_ready", req_ready, 1'b1);
        steps("pp_drain", 6);

        done_ready = 1'b0;
        push("rst_exec", 5'h12);
        push("rst_exec", 5'h05);
        step("rst_exec");
        mid_reset("rst_exec");
        steps("rst_after", 6);
        done_ready = 1'b1;
        push("rst_new", 5'h03);
        steps("rst_new", 4);

        for (int i = 0; i < 500; i++) begin
            req_valid  = ($urandom_range(0, 99) < 55);
            req_op     = OPW'($urandom);
            done_ready = ($urandom_range(0, 99) < 60);
            step("rand");
            if ($urandom_range(0, 199) == 0) mid_reset("rand_rst");
        end
        req_valid  = 1'b0;
        done_ready = 1'b1;
        steps("final_drain", 12);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
